// File: rtl/avmm_pkg.sv
// Shared types and helpers for the Avalon-MM data-width downsizer.
package avmm_pkg;

    localparam int BCW    = 4;
    localparam int MAX_SB = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic int lane_count(input int mdw, input int sdw);
        return mdw / sdw;
    endfunction

    function automatic logic lane_active(input logic [MAX_SB-1:0] slice);
        return |slice;
    endfunction

endpackage

// File: rtl/avmm_if.sv
// Avalon-MM bus bundle; master drives the request, slave drives the response.
interface avmm_if
    import avmm_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) ();

    logic [AW-1:0]   address;
    logic            read;
    logic            write;
    logic [BCW-1:0]  burstcount;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, read, write, burstcount, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, burstcount, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/avmm_lane_sel_m.sv
// Priority encoder: lowest set bit of the remaining-lane mask, plus an empty flag.
module avmm_lane_sel_m
    import avmm_pkg::*;
#(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    output logic [LW-1:0] lane,
    output logic          none
);

    always_comb begin
        lane = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) lane = LW'(i);
        end
    end

    assign none = ~|mask;

endmodule

// File: rtl/avmm_dw_downsizer_m.sv
// Splits one wide Avalon-MM access into sequential narrow accesses on active lanes,
// reassembling read lanes into a single registered wide response.
module avmm_dw_downsizer_m
    import avmm_pkg::*;
#(
    parameter int AW  = 16,
    parameter int MDW = 64,
    parameter int SDW = 32
) (
    input logic    clk,
    input logic    rst_n,
    avmm_if.slave  m,
    avmm_if.master s
);

    localparam int N   = lane_count(MDW, SDW);
    localparam int SB  = SDW / 8;
    localparam int MBE = MDW / 8;
    localparam int LW  = (N > 1) ? $clog2(N) : 1;

    if ((SDW < 8) || (SDW % 8 != 0) || (MDW % SDW != 0) || (N < 1) || ((N & (N - 1)) != 0)) begin : g_bad_widths
        $error("avmm_dw_downsizer_m: MDW/SDW must be a power of two and SDW a multiple of 8");
    end

    state_t          state, state_nxt;
    logic [AW-1:0]   base_q;
    logic [MBE-1:0]  be_q;
    logic [MDW-1:0]  wdata_q, asm_q, rdata_q, asm_merged;
    logic [N-1:0]    remain_q, remain_clr, cap_mask;
    logic [LW-1:0]   lane_q, lane_idx;
    logic            lane_none;
    logic            unused_burst;

    assign unused_burst = ^m.burstcount;

    avmm_lane_sel_m #(.N(N), .LW(LW)) u_lane_sel (
        .mask (remain_q),
        .lane (lane_idx),
        .none (lane_none)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cap_mask = '0;
        for (int i = 0; i < N; i++) begin
            cap_mask[i] = lane_active(MAX_SB'(m.byteenable[i*SB +: SB]));
        end
    end

    always_comb begin
        remain_clr = remain_q & ~(N'(1) << lane_idx);
        asm_merged = asm_q;
        asm_merged[int'(lane_q)*SDW +: SDW] = s.readdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (m.write)     state_nxt = (|cap_mask) ? ST_WR : ST_IDLE;
                else if (m.read) state_nxt = (|cap_mask) ? ST_RD : ST_RESP;
            end
            ST_WR:      if (!s.waitrequest && (remain_clr == '0)) state_nxt = ST_IDLE;
            ST_RD:      if (!s.waitrequest) state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (s.readdatavalid) state_nxt = lane_none ? ST_RESP : ST_RD;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            remain_q <= '0;
            lane_q   <= '0;
            asm_q    <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m.write || m.read) begin
                        base_q   <= m.address & ~AW'(MBE - 1);
                        be_q     <= m.byteenable;
                        wdata_q  <= m.writedata;
                        remain_q <= cap_mask;
                        asm_q    <= '0;
                        if (!m.write && (cap_mask == '0)) rdata_q <= '0;
                    end
                end
                ST_WR: if (!s.waitrequest) remain_q <= remain_clr;
                ST_RD: begin
                    if (!s.waitrequest) begin
                        remain_q <= remain_clr;
                        lane_q   <= lane_idx;
                    end
                end
                ST_RD_WAIT: begin
                    // Slave responses are only meaningful while a narrow read is outstanding.
                    if (s.readdatavalid) begin
                        asm_q <= asm_merged;
                        if (lane_none) rdata_q <= asm_merged;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m.waitrequest   = (state != ST_IDLE);
    assign m.readdatavalid = (state == ST_RESP);
    assign m.readdata      = rdata_q;

    assign s.read       = (state == ST_RD);
    assign s.write      = (state == ST_WR);
    assign s.burstcount = BCW'(1);
    assign s.address    = base_q + AW'(int'(lane_idx) * SB);
    assign s.writedata  = wdata_q[int'(lane_idx)*SDW +: SDW];
    assign s.byteenable = be_q[int'(lane_idx)*SB +: SB];

endmodule

// File: tb/tb_avmm_dw_downsizer_m.sv
// Scoreboard bench for avmm_dw_downsizer_m (MDW=64, SDW=32): directed vectors,
// a slave model that checks narrow accesses and a monitor that checks wide responses.
module tb_avmm_dw_downsizer_m;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;   // write data, or read response data
        logic [3:0]  be;
        int          waits;
        int          lat;
    } s_exp_t;

    typedef struct {
        logic [63:0] data;
        bit          chk_lat;
    } m_exp_t;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_srdv_cyc = -100;

    s_exp_t exp_s[$];
    m_exp_t exp_m[$];

    avmm_if #(.AW(16), .DW(64)) m_bus ();
    avmm_if #(.AW(16), .DW(32)) s_bus ();

    avmm_dw_downsizer_m #(.AW(16), .MDW(64), .SDW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m     (m_bus),
        .s     (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model and narrow-side scoreboard.
    initial begin : slave_model
        int          wait_cnt = 0;
        int          pending = 0;
        bit          outstanding = 0;
        logic [31:0] pend_data = '0;
        logic [15:0] hold_addr = '0;
        s_exp_t      e;
        s_bus.waitrequest   = 1'b0;
        s_bus.readdata      = 32'h0BAD_0BAD;
        s_bus.readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            s_bus.readdatavalid = 1'b0;
            if (!rst_n) begin
                s_bus.waitrequest = 1'b0;
                wait_cnt = 0;
                pending = 0;
                outstanding = 0;
            end else begin
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        s_bus.readdatavalid = 1'b1;
                        s_bus.readdata      = pend_data;
                        last_srdv_cyc       = cyc;
                        outstanding         = 0;
                    end
                end
                if (s_bus.read || s_bus.write) begin
                    if (exp_s.size() == 0) begin
                        check("s_unexpected_access", 64'({s_bus.write, s_bus.read}), 64'(0));
                        s_bus.waitrequest = 1'b0;
                    end else begin
                        e = exp_s[0];
                        if (wait_cnt > 0) check("s_hold_addr", 64'(s_bus.address), 64'(hold_addr));
                        else hold_addr = s_bus.address;
                        if (wait_cnt < e.waits) begin
                            s_bus.waitrequest = 1'b1;
                            wait_cnt++;
                        end else begin
                            s_bus.waitrequest = 1'b0;
                            wait_cnt = 0;
                            void'(exp_s.pop_front());
                            check("s_is_write", 64'(s_bus.write), 64'(e.wr));
                            check("s_address", 64'(s_bus.address), 64'(e.addr));
                            check("s_byteenable", 64'(s_bus.byteenable), 64'(e.be));
                            check("s_burstcount", 64'(s_bus.burstcount), 64'(1));
                            if (e.wr) begin
                                check("s_writedata", 64'(s_bus.writedata), 64'(e.data));
                            end else begin
                                check("s_rd_overlap", 64'(outstanding), 64'(0));
                                pending     = e.lat;
                                pend_data   = e.data;
                                outstanding = 1;
                            end
                        end
                    end
                end else begin
                    s_bus.waitrequest = 1'b0;
                    wait_cnt = 0;
                end
            end
        end
    end

    // Wide-side response monitor.
    initial begin : master_monitor
        m_exp_t me;
        forever begin
            @(negedge clk);
            if (rst_n && m_bus.readdatavalid) begin
                if (exp_m.size() == 0) begin
                    check("m_unexpected_rdv", 64'(m_bus.readdatavalid), 64'(0));
                end else begin
                    me = exp_m.pop_front();
                    check("m_readdata", m_bus.readdata, me.data);
                    if (me.chk_lat) check("m_rdv_latency", 64'(cyc - last_srdv_cyc), 64'(1));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_read"}, 64'(s_bus.read), 64'(0));
        check({tag, "_s_write"}, 64'(s_bus.write), 64'(0));
        check({tag, "_m_rdv"}, 64'(m_bus.readdatavalid), 64'(0));
        check({tag, "_m_waitreq"}, 64'(m_bus.waitrequest), 64'(0));
        check({tag, "_m_readdata"}, m_bus.readdata, 64'(0));
        check({tag, "_s_address"}, 64'(s_bus.address), 64'(0));
        check({tag, "_s_writedata"}, 64'(s_bus.writedata), 64'(0));
        check({tag, "_s_byteenable"}, 64'(s_bus.byteenable), 64'(0));
    endtask

    task automatic wait_s_empty();
        int n = 0;
        while (exp_s.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_s.size() != 0) begin
            check("s_timeout", 64'(exp_s.size()), 64'(0));
            exp_s.delete();
        end
    endtask

    task automatic wait_m_empty();
        int n = 0;
        while (exp_m.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_m.size() != 0) begin
            check("m_timeout", 64'(exp_m.size()), 64'(0));
            exp_m.delete();
        end
    endtask

    task automatic m_issue(input bit wr, input logic [15:0] addr, input logic [7:0] be,
                           input logic [63:0] data, input logic [3:0] bc);
        int n = 0;
        @(posedge clk); #1;
        m_bus.write      = wr;
        m_bus.read       = ~wr;
        m_bus.address    = addr;
        m_bus.byteenable = be;
        m_bus.writedata  = data;
        m_bus.burstcount = bc;
        @(negedge clk);
        while (m_bus.waitrequest && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("m_accept", 64'(m_bus.waitrequest), 64'(0));
        @(posedge clk); #1;
        m_bus.write = 1'b0;
        m_bus.read  = 1'b0;
    endtask

    task automatic m_write(input logic [15:0] addr, input logic [7:0] be, input logic [63:0] data,
                           input logic [3:0] bc, input int exp_wait_hi);
        int wh = 0;
        m_issue(1'b1, addr, be, data, bc);
        @(negedge clk);
        while (m_bus.waitrequest && wh < 100) begin
            wh++;
            @(negedge clk);
        end
        check("m_wait_cycles", 64'(wh), 64'(exp_wait_hi));
        wait_s_empty();
    endtask

    task automatic m_read(input logic [15:0] addr, input logic [7:0] be, input logic [63:0] exp_data,
                          input bit chk_lat);
        exp_m.push_back('{exp_data, chk_lat});
        m_issue(1'b0, addr, be, 64'h0, 4'd1);
        wait_m_empty();
        wait_s_empty();
    endtask

    initial begin : stimulus
        rst_n            = 1'b0;
        m_bus.address    = '0;
        m_bus.read       = 1'b0;
        m_bus.write      = 1'b0;
        m_bus.burstcount = 4'd1;
        m_bus.writedata  = '0;
        m_bus.byteenable = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single low-lane write.
        exp_s.push_back('{1'b1, 16'h0010, 32'h3333_4444, 4'hF, 0, 0});
        m_write(16'h0010, 8'h0F, 64'h1111_2222_3333_4444, 4'd1, 1);

        // Full write with slave stalling lane 0 for two cycles.
        exp_s.push_back('{1'b1, 16'h0018, 32'h1234_5678, 4'hF, 2, 0});
        exp_s.push_back('{1'b1, 16'h001C, 32'hCAFE_F00D, 4'hF, 0, 0});
        m_write(16'h0018, 8'hFF, 64'hCAFE_F00D_1234_5678, 4'd1, 4);

        // Unaligned address, partial upper lane, burstcount ignored.
        exp_s.push_back('{1'b1, 16'h0014, 32'h00AB_0000, 4'h3, 0, 0});
        m_write(16'h0013, 8'h30, 64'h00AB_0000_0000_0000, 4'd3, 1);

        // Upper-lane read, slave responds two cycles after acceptance.
        exp_s.push_back('{1'b0, 16'h0024, 32'hDEAD_BEEF, 4'hF, 0, 2});
        m_read(16'h0020, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b1);

        // Full read, two sequential narrow reads.
        exp_s.push_back('{1'b0, 16'h0030, 32'hAAAA_0000, 4'hF, 1, 1});
        exp_s.push_back('{1'b0, 16'h0034, 32'h5555_FFFF, 4'hF, 0, 3});
        m_read(16'h0030, 8'hFF, 64'h5555_FFFF_AAAA_0000, 1'b1);
        repeat (3) @(negedge clk);
        check("m_readdata_hold", m_bus.readdata, 64'h5555_FFFF_AAAA_0000);

        // Empty byteenable: read returns zero without slave traffic, write is dropped.
        m_read(16'h0040, 8'h00, 64'h0, 1'b0);
        m_write(16'h0048, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 0);

        // Reset right after lane 0 of a full write is accepted.
        exp_s.push_back('{1'b1, 16'h0050, 32'h89AB_CDEF, 4'hF, 0, 0});
        m_issue(1'b1, 16'h0050, 8'hFF, 64'h0123_4567_89AB_CDEF, 4'd1);
        wait_s_empty();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle_wait", 64'(m_bus.waitrequest), 64'(0));

        // Normal transaction after the abandoned one.
        exp_s.push_back('{1'b0, 16'h0060, 32'h1357_9BDF, 4'hF, 0, 1});
        m_read(16'h0060, 8'h0F, 64'h0000_0000_1357_9BDF, 1'b1);

        repeat (5) @(negedge clk);
        check("s_queue_drained", 64'(exp_s.size()), 64'(0));
        check("m_queue_drained", 64'(exp_m.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
